// File: rtl/sdram_client_responder.sv
// BRAM-backed stand-in for the sdram controller client interface: one command at a time.
// Define SDRAM_CLIENT_RESPONDER_REFRESH_EN to model periodic refresh stalls in IDLE.
module sdram_client_responder #(
    parameter int unsigned AMSB       = 19,
    parameter int unsigned DMSB       = 15,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned T_RI       = 32,
    parameter int unsigned T_RFC      = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AMSB:0]   rd_addr,
    input  logic [3:0]      rd_len,
    input  logic            rd_req,
    output logic            rd_ack,
    output logic [DMSB:0]   rd_data,
    output logic            rd_rdy,
    input  logic [AMSB:0]   wr_addr,
    input  logic [3:0]      wr_len,
    input  logic [DMSB:0]   wr_data,
    input  logic            wr_req,
    output logic            wr_ack
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    typedef enum logic [2:0] {
        StIdle,
        StWrBeat,
        StWrGap,
        StRdWait,
        StRdBurst
`ifdef SDRAM_CLIENT_RESPONDER_REFRESH_EN
        ,
        StRefresh
`endif
    } state_e;

    logic [DMSB:0] mem [Depth];

    state_e        state_q, state_d;
    ptr_t          ptr_q, ptr_d;
    logic [3:0]    beats_q, beats_d;
    logic [3:0]    wait_q, wait_d;
    logic          rd_ack_q, rd_ack_d;
    logic          rd_rdy_q, rd_rdy_d;
    logic          wr_ack_q, wr_ack_d;
    logic [DMSB:0] rd_data_q;
    logic          mem_we;
    logic          rd_load;
    ptr_t          mem_idx;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{rd_addr[AMSB:DEPTH_LOG2], wr_addr[AMSB:DEPTH_LOG2]};

`ifdef SDRAM_CLIENT_RESPONDER_REFRESH_EN
    localparam int unsigned RiW  = (T_RI > 1) ? $clog2(T_RI) : 1;
    localparam int unsigned RfcW = (T_RFC > 1) ? $clog2(T_RFC) : 1;

    logic [RiW-1:0]  ri_q;
    logic [RfcW-1:0] rfc_q, rfc_d;
    logic            ref_pend_q, ref_pend_d;
    logic            ref_tick;
    logic            ref_clr;

    assign ref_tick   = (ri_q == RiW'(T_RI - 1));
    assign ref_pend_d = ref_tick | (ref_pend_q & ~ref_clr);

    // Free-running interval counter; a due refresh is held until the FSM reaches IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ri_q       <= '0;
            rfc_q      <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            ri_q       <= ref_tick ? '0 : ri_q + RiW'(1);
            rfc_q      <= rfc_d;
            ref_pend_q <= ref_pend_d;
        end
    end
`else
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = (T_RI + T_RFC) != 0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        beats_d  = beats_q;
        wait_d   = wait_q;
        rd_ack_d = 1'b0;
        rd_rdy_d = 1'b0;
        wr_ack_d = 1'b0;
        mem_we   = 1'b0;
        rd_load  = 1'b0;
        mem_idx  = ptr_q;
`ifdef SDRAM_CLIENT_RESPONDER_REFRESH_EN
        rfc_d    = rfc_q;
        ref_clr  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
`ifdef SDRAM_CLIENT_RESPONDER_REFRESH_EN
                if (ref_pend_q) begin
                    state_d = StRefresh;
                    rfc_d   = RfcW'(T_RFC - 1);
                    ref_clr = 1'b1;
                end else
`endif
                if (rd_req) begin
                    state_d  = StRdWait;
                    rd_ack_d = 1'b1;
                    ptr_d    = rd_addr[DEPTH_LOG2-1:0];
                    beats_d  = rd_len;
                    wait_d   = 4'(RD_LATENCY - 1);
                end else if (wr_req) begin
                    // First beat is written on the accepting edge itself.
                    state_d  = StWrGap;
                    wr_ack_d = 1'b1;
                    mem_we   = 1'b1;
                    mem_idx  = wr_addr[DEPTH_LOG2-1:0];
                    ptr_d    = wr_addr[DEPTH_LOG2-1:0] + ptr_t'(1);
                    beats_d  = wr_len;
                end
            end
            StWrGap: begin
                if (beats_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StWrBeat;
                    beats_d = beats_q - 4'd1;
                end
            end
            StWrBeat: begin
                state_d  = StWrGap;
                wr_ack_d = 1'b1;
                mem_we   = 1'b1;
                ptr_d    = ptr_q + ptr_t'(1);
            end
            StRdWait: begin
                if (wait_q == 4'd0) begin
                    state_d  = StRdBurst;
                    rd_load  = 1'b1;
                    rd_rdy_d = 1'b1;
                    ptr_d    = ptr_q + ptr_t'(1);
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StRdBurst: begin
                // beats_q counts beats still to issue after the one now on the bus.
                if (beats_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    rd_load  = 1'b1;
                    rd_rdy_d = 1'b1;
                    ptr_d    = ptr_q + ptr_t'(1);
                    beats_d  = beats_q - 4'd1;
                end
            end
`ifdef SDRAM_CLIENT_RESPONDER_REFRESH_EN
            StRefresh: begin
                if (rfc_q == '0) begin
                    state_d = StIdle;
                end else begin
                    rfc_d = rfc_q - RfcW'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            beats_q  <= '0;
            wait_q   <= '0;
            rd_ack_q <= 1'b0;
            rd_rdy_q <= 1'b0;
            wr_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            beats_q  <= beats_d;
            wait_q   <= wait_d;
            rd_ack_q <= rd_ack_d;
            rd_rdy_q <= rd_rdy_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    // Storage is never reset; contents survive a reset_n pulse.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            mem[mem_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_load) begin
            rd_data_q <= mem[mem_idx];
        end
    end

    assign rd_ack  = rd_ack_q;
    assign rd_rdy  = rd_rdy_q;
    assign wr_ack  = wr_ack_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sdram_client_responder.sv
// Directed plus randomized bench for sdram_client_responder against an array reference model.
module tb_sdram_client_responder;

    localparam int RdLat = 2;
`ifdef SDRAM_CLIENT_RESPONDER_REFRESH_EN
    localparam int ExpLat = -1;
`else
    localparam int ExpLat = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [19:0] rd_addr, wr_addr;
    logic [3:0]  rd_len, wr_len;
    logic        rd_req, wr_req;
    logic        rd_ack, rd_rdy, wr_ack;
    logic [15:0] rd_data, wr_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rd_ack_cnt = 0;
    int wr_ack_cnt = 0;
    logic [15:0] model [int];

    sdram_client_responder #(
        .AMSB(19), .DMSB(15), .DEPTH_LOG2(12), .RD_LATENCY(RdLat), .T_RI(32), .T_RFC(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_len(rd_len), .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_rdy(rd_rdy),
        .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data), .wr_req(wr_req),
        .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rd_ack) rd_ack_cnt++;
        if (wr_ack) wr_ack_cnt++;
    end

    function automatic int idx(input logic [19:0] a, input int i);
        return int'((a + 20'(i)) & 20'hFFF);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [19:0] addr, input logic [3:0] len,
                            input logic [15:0] base, input int exp_lat, input string tag);
        int t_set, t_prev, c0;
        bit got;
        c0 = wr_ack_cnt;
        wr_addr = addr; wr_len = len; wr_data = base; wr_req = 1'b1;
        t_set = cyc; t_prev = cyc;
        for (int i = 0; i <= int'(len); i++) begin
            got = 1'b0;
            for (int k = 0; k < 64 && !got; k++) begin
                @(negedge clk);
                got = wr_ack;
            end
            check({tag, " wr_ack seen"}, 32'(got), 32'd1);
            if (!got) begin
                wr_req = 1'b0;
                return;
            end
            if (i == 0) begin
                if (exp_lat >= 0) check({tag, " wr_ack latency"}, cyc - t_set, exp_lat);
            end else begin
                check({tag, " wr_ack spacing"}, cyc - t_prev, 2);
            end
            t_prev = cyc;
            model[idx(addr, i)] = base + 16'(i);
            @(posedge clk); #1;
            wr_len = 4'($urandom);
            if (i < int'(len)) wr_data = base + 16'(i + 1);
            else wr_req = 1'b0;
        end
        repeat (3) @(negedge clk);
        check({tag, " wr_ack count"}, wr_ack_cnt - c0, int'(len) + 1);
    endtask

    task automatic collect(input logic [19:0] addr, input logic [3:0] len, input int ack_cyc,
                           input string tag, output int last_cyc);
        bit got;
        logic [15:0] exp;
        got = 1'b0;
        last_cyc = cyc;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = rd_rdy;
        end
        check({tag, " rd_rdy seen"}, 32'(got), 32'd1);
        if (!got) return;
        check({tag, " rd latency"}, cyc - ack_cyc, RdLat);
        exp = '0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i > 0) @(negedge clk);
            exp = model[idx(addr, i)];
            check({tag, " rd_rdy beat"}, 32'(rd_rdy), 32'd1);
            check({tag, " rd_data beat"}, 32'(rd_data), 32'(exp));
        end
        last_cyc = cyc;
        @(negedge clk);
        check({tag, " rd_rdy after burst"}, 32'(rd_rdy), 32'd0);
        check({tag, " rd_data hold"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_read(input logic [19:0] addr, input logic [3:0] len, input int exp_lat,
                           input string tag);
        int t_set, ack_cyc, last, c0;
        bit got;
        c0 = rd_ack_cnt;
        rd_addr = addr; rd_len = len; rd_req = 1'b1;
        t_set = cyc;
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = rd_ack;
        end
        check({tag, " rd_ack seen"}, 32'(got), 32'd1);
        if (!got) begin
            rd_req = 1'b0;
            return;
        end
        ack_cyc = cyc;
        if (exp_lat >= 0) check({tag, " rd_ack latency"}, cyc - t_set, exp_lat);
        @(posedge clk); #1;
        rd_req = 1'b0; rd_len = 4'($urandom); rd_addr = 20'($urandom);
        collect(addr, len, ack_cyc, tag, last);
        check({tag, " rd_ack count"}, rd_ack_cnt - c0, 1);
    endtask

    initial begin
        int ack_cyc, last, cr, cw, n;
        bit got;
        logic [19:0] a;
        logic [3:0] l, rl;
        int off;

        reset_n = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rd_ack", 32'(rd_ack), 32'd0);
        check("reset rd_rdy", 32'(rd_rdy), 32'd0);
        check("reset wr_ack", 32'(wr_ack), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // single-word write and read
        do_write(20'h00010, 4'd0, 16'hBEEF, ExpLat, "t1");
        do_read(20'h00010, 4'd0, ExpLat, "t1");

        // 16-word burst across the array end
        do_write(20'h00FF8, 4'd15, 16'h1000, ExpLat, "t2");
        do_read(20'h00FF8, 4'd15, ExpLat, "t2");

        // simultaneous requests: read first, then write
        cr = rd_ack_cnt; cw = wr_ack_cnt;
        rd_addr = 20'h00010; rd_len = 4'd0;
        wr_addr = 20'h00777; wr_len = 4'd0; wr_data = 16'h3C3C;
        rd_req = 1'b1; wr_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = rd_ack;
        end
        check("t3 rd_ack seen", 32'(got), 32'd1);
        check("t3 wr_ack held off", 32'(wr_ack), 32'd0);
        ack_cyc = cyc;
        @(posedge clk); #1;
        rd_req = 1'b0;
        collect(20'h00010, 4'd0, ack_cyc, "t3", last);
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            got = wr_ack;
            if (!got) @(negedge clk);
        end
        check("t3 wr_ack seen", 32'(got), 32'd1);
`ifndef SDRAM_CLIENT_RESPONDER_REFRESH_EN
        check("t3 wr_ack after burst", cyc - last, 2);
`endif
        model[idx(20'h00777, 0)] = 16'h3C3C;
        @(posedge clk); #1;
        wr_req = 1'b0;
        repeat (4) @(negedge clk);
        check("t3 rd_ack count", rd_ack_cnt - cr, 1);
        check("t3 wr_ack count", wr_ack_cnt - cw, 1);
        do_read(20'h00777, 4'd0, ExpLat, "t3 rb");

        // reset during beat 5 of a 16-beat read
        do_write(20'h00200, 4'd15, 16'h5000, ExpLat, "t4 wr");
        rd_addr = 20'h00200; rd_len = 4'd15; rd_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = rd_ack;
        end
        check("t4 rd_ack seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        rd_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = rd_rdy;
        end
        check("t4 rd_rdy seen", 32'(got), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("t4 pre-reset beat", 32'(rd_data), 32'(model[idx(20'h00200, i)]));
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("t4 rd_rdy after reset", 32'(rd_rdy), 32'd0);
        check("t4 rd_data after reset", 32'(rd_data), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_rdy || rd_ack || wr_ack) n++;
        end
        check("t4 no beats after reset", n, 0);
        @(posedge clk); #1;
        do_read(20'h00200, 4'd15, ExpLat, "t4 rb");

        // address aliasing above DEPTH_LOG2
        do_write(20'h81234, 4'd0, 16'hA5A5, ExpLat, "t5");
        do_read(20'h01234, 4'd0, ExpLat, "t5");
        check("t5 model alias", 32'(model[idx(20'h01234, 0)]), 32'hA5A5);

        // randomized bursts, reading back a random sub-range
        for (int r = 0; r < 8; r++) begin
            a = 20'($urandom);
            l = 4'($urandom);
            do_write(a, l, 16'($urandom), ExpLat, "rnd wr");
            off = int'($urandom_range(0, int'(l)));
            rl = 4'($urandom_range(0, int'(l) - off));
            do_read(a + 20'(off), rl, ExpLat, "rnd rd");
        end

`ifdef SDRAM_CLIENT_RESPONDER_REFRESH_EN
        // back-to-back reads across refresh windows
        cr = rd_ack_cnt;
        for (int r = 0; r < 20; r++) do_read(20'h00010, 4'd0, -1, "t6");
        check("t6 rd_ack count", rd_ack_cnt - cr, 20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
